// File: rtl/instr_mem_if.sv
// Fetch/response/load bus between the fetch stage and the instruction memory.
// The master side is the fetch stage and the program loader; the slave side is the memory.
interface instr_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;
    logic              flush;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;

    modport master (
        output fetch_valid, fetch_addr, rsp_ready, flush, load_en, load_addr, load_data,
        input  fetch_ready, rsp_valid, rsp_instr, rsp_fault, load_err
    );

    modport slave (
        input  fetch_valid, fetch_addr, rsp_ready, flush, load_en, load_addr, load_data,
        output fetch_ready, rsp_valid, rsp_instr, rsp_fault, load_err
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with a one-entry response register,
// run-time program load port and fault reporting for bad fetch/load addresses.
module instr_mem_sync #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                BYTE_ADDR  = 1,
    parameter logic [DATA_W-1:0] FAULT_WORD = DATA_W'(32'hE1A00000)
) (
    input logic          clk,
    input logic          rst_n,
    instr_mem_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              vld_p1;
    logic [DATA_W-1:0] instr_p1;
    logic              fault_p1;
    logic              err_p1;
    logic              accept;
    logic              fetch_bad;
    logic              load_bad;

    function automatic logic [ADDR_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        if (BYTE_ADDR != 0) return a >> 2;
        return a;
    endfunction

    // Range test keeps the full index width, so large addresses never alias into the array.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        logic mis;
        mis = (BYTE_ADDR != 0) && (a[1:0] != 2'b00);
        return mis || ((to_idx(a) >> IW) != '0);
    endfunction

    assign fetch_bad       = addr_bad(bus.fetch_addr);
    assign load_bad        = addr_bad(bus.load_addr);
    assign bus.fetch_ready = rst_n && !bus.flush && !bus.load_en && (!vld_p1 || bus.rsp_ready);
    assign accept          = bus.fetch_valid && bus.fetch_ready;

    always_ff @(posedge clk) begin
        if (rst_n && bus.load_en && !load_bad) begin
            mem[IW'(to_idx(bus.load_addr))] <= bus.load_data;
        end
    end

    // p0 -> p1: request accepted at this edge becomes the held response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            fault_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            err_p1 <= bus.load_en && load_bad;
            if (accept) begin
                vld_p1   <= 1'b1;
                instr_p1 <= fetch_bad ? FAULT_WORD : mem[IW'(to_idx(bus.fetch_addr))];
                fault_p1 <= fetch_bad;
            end else if (bus.flush || bus.rsp_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_instr = instr_p1;
    assign bus.rsp_fault = fault_p1;
    assign bus.load_err  = err_p1;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: scoreboard of expected responses plus table-driven
// fetches and hand-written sequences for backpressure, flush, load and reset.
module tb_instr_mem_sync;
    localparam logic [31:0] FW = 32'hE1A00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    rsp_t sb[$];
    vec_t vecs[8];

    instr_mem_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    instr_mem_sync #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BYTE_ADDR(1), .FAULT_WORD(FW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A response leaves the register when it is taken or flushed.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && (bus.rsp_ready || bus.flush)) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_instr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_instr", 64'(bus.rsp_instr), 64'(e.instr));
                check("rsp_fault", 64'(bus.rsp_fault), 64'(e.fault));
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        #1;
        check("load_blocks_fetch", 64'(bus.fetch_ready), 64'd0);
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] instr, input logic fault);
        bit ok;
        ok = 0;
        bus.fetch_addr  = a;
        bus.fetch_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            if (bus.fetch_ready) begin
                sb.push_back('{instr: instr, fault: fault});
                ok = 1;
            end
            tick();
        end
        bus.fetch_valid = 1'b0;
        check("fetch_accepted", 64'(ok), 64'd1);
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, instr: 32'hE04E500E, fault: 1'b0};
        vecs[1] = '{addr: 32'h0000_0004, instr: 32'hE2850007, fault: 1'b0};
        vecs[2] = '{addr: 32'h0000_00FC, instr: 32'hCAFEF00D, fault: 1'b0};
        vecs[3] = '{addr: 32'h0000_0102, instr: FW,           fault: 1'b1};
        vecs[4] = '{addr: 32'h0000_0100, instr: FW,           fault: 1'b1};
        vecs[5] = '{addr: 32'h0000_0001, instr: FW,           fault: 1'b1};
        vecs[6] = '{addr: 32'hFFFF_FFFC, instr: FW,           fault: 1'b1};
        vecs[7] = '{addr: 32'h0000_0400, instr: FW,           fault: 1'b1};

        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;
        bus.rsp_ready   = 1'b0;
        bus.flush       = 1'b0;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;

        tick();
        tick();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_instr", 64'(bus.rsp_instr), 64'd0);
        check("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        check("rst_load_err", 64'(bus.load_err), 64'd0);
        check("rst_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_fetch_ready", 64'(bus.fetch_ready), 64'd1);

        bus.rsp_ready = 1'b1;
        do_load(32'h0, 32'hE04E500E);
        do_load(32'h4, 32'hE2850007);
        do_load(32'hFC, 32'hCAFEF00D);
        check("good_load_err", 64'(bus.load_err), 64'd0);

        // back-to-back fetches at full throughput
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0;
        #1;
        check("b2b_ready0", 64'(bus.fetch_ready), 64'd1);
        sb.push_back('{instr: 32'hE04E500E, fault: 1'b0});
        tick();
        bus.fetch_addr = 32'h4;
        #1;
        check("b2b_instr0", 64'(bus.rsp_instr), 64'hE04E500E);
        check("b2b_ready1", 64'(bus.fetch_ready), 64'd1);
        sb.push_back('{instr: 32'hE2850007, fault: 1'b0});
        tick();
        bus.fetch_valid = 1'b0;
        check("b2b_instr1", 64'(bus.rsp_instr), 64'hE2850007);
        check("b2b_valid1", 64'(bus.rsp_valid), 64'd1);
        tick();
        check("drain_valid", 64'(bus.rsp_valid), 64'd0);

        // backpressure holds the response stable
        bus.rsp_ready = 1'b0;
        do_fetch(32'h0, 32'hE04E500E, 1'b0);
        bus.fetch_addr  = 32'h4;
        bus.fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_instr", 64'(bus.rsp_instr), 64'hE04E500E);
            check("bp_ready", 64'(bus.fetch_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        do_fetch(32'h4, 32'hE2850007, 1'b0);
        check("bp_next_instr", 64'(bus.rsp_instr), 64'hE2850007);
        tick();

        foreach (vecs[i]) do_fetch(vecs[i].addr, vecs[i].instr, vecs[i].fault);
        tick();

        // dropped loads pulse load_err and leave memory intact
        do_load(32'h3, 32'hDEADBEEF);
        check("lerr_pulse", 64'(bus.load_err), 64'd1);
        tick();
        check("lerr_clear", 64'(bus.load_err), 64'd0);
        do_load(32'h100, 32'hDEADBEEF);
        check("lerr_range", 64'(bus.load_err), 64'd1);
        do_fetch(32'h0, 32'hE04E500E, 1'b0);
        check("lerr_one_cycle", 64'(bus.load_err), 64'd0);
        tick();

        // flush drops a held response
        bus.rsp_ready = 1'b0;
        do_fetch(32'h0, 32'hE04E500E, 1'b0);
        tick();
        bus.fetch_addr  = 32'h4;
        bus.fetch_valid = 1'b1;
        bus.flush       = 1'b1;
        #1;
        check("flush_ready", 64'(bus.fetch_ready), 64'd0);
        tick();
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        check("flush_valid", 64'(bus.rsp_valid), 64'd0);
        do_fetch(32'h4, 32'hE2850007, 1'b0);
        bus.rsp_ready = 1'b1;
        tick();

        // flush and load together
        bus.rsp_ready = 1'b0;
        do_fetch(32'h4, 32'hE2850007, 1'b0);
        bus.flush     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 32'hC;
        bus.load_data = 32'hA5A5A5A5;
        #1;
        check("fl_ld_ready", 64'(bus.fetch_ready), 64'd0);
        tick();
        bus.flush   = 1'b0;
        bus.load_en = 1'b0;
        check("fl_ld_valid", 64'(bus.rsp_valid), 64'd0);
        check("fl_ld_err", 64'(bus.load_err), 64'd0);
        bus.rsp_ready = 1'b1;
        do_fetch(32'hC, 32'hA5A5A5A5, 1'b0);
        tick();

        // read right after load
        do_load(32'h8, 32'h12345678);
        do_fetch(32'h8, 32'h12345678, 1'b0);
        tick();

        // reset drops a held response, memory survives
        bus.rsp_ready = 1'b0;
        do_fetch(32'h8, 32'h12345678, 1'b0);
        tick();
        check("rst_held_queue", 64'(sb.size()), 64'd1);
        rst_n = 1'b0;
        tick();
        check("rst_drop_valid", 64'(bus.rsp_valid), 64'd0);
        sb.delete();
        rst_n = 1'b1;
        tick();
        bus.rsp_ready = 1'b1;
        do_fetch(32'h8, 32'h12345678, 1'b0);
        tick();

        // load to the index of a held response does not disturb it
        bus.rsp_ready = 1'b0;
        do_fetch(32'h8, 32'h12345678, 1'b0);
        do_load(32'h8, 32'h87654321);
        check("held_ld_instr", 64'(bus.rsp_instr), 64'h12345678);
        check("held_ld_valid", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        tick();
        do_fetch(32'h8, 32'h87654321, 1'b0);

        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
